// File: rtl/seq_det_pkg.sv
// Shared definitions for the bit-serial pattern detector path.
package seq_det_pkg;

    typedef enum logic {
        StIdle,
        StShift
    } scan_state_e;

    localparam int unsigned DEF_PAT_LEN = 4;
    // Pattern right-aligned; the low DEF_PAT_LEN bits are used.
    localparam logic [7:0]  DEF_PATTERN = 8'b0000_0110;

endpackage

// File: rtl/seq_match_core.sv
// Overlapping pattern matcher: keeps the last PAT_LEN-1 bits plus a fill count,
// and flags a hit combinationally in the cycle the completing bit is presented.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0]   PATTERN = PAT_LEN'(DEF_PATTERN)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic bit_in,
    input  logic bit_en,
    output logic match
);

    localparam int unsigned        FILL_W = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [FILL_W-1:0]  PRIMED = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] prev_q, prev_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_LEN-1:0] window;

    always_comb begin
        window = {prev_q, bit_in};
        prev_d = window[PAT_LEN-2:0];
        fill_d = fill_q;
        if (fill_q != PRIMED) begin
            fill_d = fill_q + 1'b1;
        end
        // A hit needs PAT_LEN real bits: PAT_LEN-1 stored plus the current one.
        match = bit_en & ~clear & (fill_q == PRIMED) & (window == PATTERN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            fill_q <= '0;
        end else if (clear) begin
            prev_q <= '0;
            fill_q <= '0;
        end else if (bit_en) begin
            prev_q <= prev_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Byte-stream scan controller: valid/ready byte intake, MSB-first serialiser,
// pattern matcher, saturating hit counter and sticky threshold interrupt.
module seq_scan_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0]   PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic [CNT_W-1:0] threshold,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             irq,
    output logic             busy
);

    scan_state_e      state_q, state_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       byte_q, byte_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_q, irq_d;
    logic             pulse_q;
    logic             accept;
    logic             match;

    // Reset gating keeps in_ready low while reset is held, regardless of enable.
    assign in_ready = enable & ~clear & ~reset &
                      ((state_q == StIdle) | (bit_idx_q == 3'd0));
    assign accept    = in_valid & in_ready;
    assign bit_valid = (state_q == StShift);
    assign busy      = bit_valid;
    assign bit_out   = bit_valid & byte_q[bit_idx_q];

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        byte_d    = byte_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StShift;
                    bit_idx_d = 3'd7;
                    byte_d    = in_data;
                end
            end
            StShift: begin
                if (bit_idx_q != 3'd0) begin
                    bit_idx_d = bit_idx_q - 3'd1;
                end else if (accept) begin
                    // Back-to-back byte: reload without an idle bubble.
                    bit_idx_d = 3'd7;
                    byte_d    = in_data;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
        if (clear) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        count_d = count_q;
        if (match && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
        irq_d = irq_q | ((threshold != '0) && (count_d >= threshold));
        if (clear) begin
            count_d = '0;
            irq_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_idx_q <= 3'd0;
            byte_q    <= 8'd0;
            count_q   <= '0;
            irq_q     <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            byte_q    <= byte_d;
            count_q   <= count_d;
            irq_q     <= irq_d;
            pulse_q   <= match & ~clear;
        end
    end

    assign match_pulse = pulse_q;
    assign match_count = count_q;
    assign irq         = irq_q;

    seq_match_core #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_match_core (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .bit_in (bit_out),
        .bit_en (bit_valid),
        .match  (match)
    );

endmodule
